// File: rtl/fadd_issue.sv
// fadd_issue: issue/retire controller wrapped around a pipelined fadd.
// Credit-gated admission, shadow tag pipeline, in-order result FIFO.
module fadd_issue #(
  parameter int NSTAGE = 2,
  parameter int TAGW   = 4
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic [31:0]                  req_x1,
  input  logic [31:0]                  req_x2,
  input  logic [TAGW-1:0]              req_tag,
  output logic [31:0]                  fadd_x1,
  output logic [31:0]                  fadd_x2,
  output logic                         fadd_enable_in,
  input  logic                         fadd_enable_out,
  input  logic [31:0]                  fadd_y,
  input  logic                         fadd_ovf,
  output logic                         res_valid,
  input  logic                         res_ready,
  output logic [31:0]                  res_y,
  output logic                         res_ovf,
  output logic [TAGW-1:0]              res_tag,
  output logic [$clog2(NSTAGE+3)-1:0]  credits_used,
  output logic                         proto_err
);

  localparam int DEPTH = NSTAGE + 2;
  localparam int CW    = $clog2(DEPTH + 1);
  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int EW    = 33 + TAGW;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [PW-1:0] LAST_P  = PW'(DEPTH - 1);

  logic [31:0]     x1_q, x1_d;
  logic [31:0]     x2_q, x2_d;
  logic            en_q, en_d;
  logic [TAGW-1:0] itag_q, itag_d;

  logic [NSTAGE-1:0] sv_q, sv_d;
  logic [TAGW-1:0]   st_q [NSTAGE];
  logic [TAGW-1:0]   st_d [NSTAGE];

  logic [EW-1:0] mem_q [DEPTH];
  logic [EW-1:0] mem_d [DEPTH];
  logic [PW-1:0] wp_q, wp_d;
  logic [PW-1:0] rp_q, rp_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] cred_q, cred_d;
  logic          perr_q, perr_d;

  logic accept;
  logic pop;
  logic push;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == LAST_P) ? '0 : p + 1'b1;
  endfunction

  assign req_ready      = (cred_q < DEPTH_C);
  assign res_valid      = (cnt_q != '0);
  assign fadd_x1        = x1_q;
  assign fadd_x2        = x2_q;
  assign fadd_enable_in = en_q;
  assign res_y          = mem_q[rp_q][EW-1 -: 32];
  assign res_ovf        = mem_q[rp_q][TAGW];
  assign res_tag        = mem_q[rp_q][TAGW-1:0];
  assign credits_used   = cred_q;
  assign proto_err      = perr_q;

  // Next state: issue regs, shadow shift, FIFO and credit bookkeeping.
  always_comb begin
    accept = req_valid & req_ready;
    pop    = res_valid & res_ready;
    push   = sv_q[NSTAGE-1];
    x1_d   = x1_q;
    x2_d   = x2_q;
    itag_d = itag_q;
    en_d   = accept;
    if (accept) begin
      x1_d   = req_x1;
      x2_d   = req_x2;
      itag_d = req_tag;
    end
    sv_d    = sv_q;
    st_d    = st_q;
    sv_d[0] = en_q;
    st_d[0] = itag_q;
    for (int i = 1; i < NSTAGE; i++) begin
      sv_d[i] = sv_q[i-1];
      st_d[i] = st_q[i-1];
    end
    mem_d = mem_q;
    wp_d  = wp_q;
    rp_d  = rp_q;
    if (push) begin
      mem_d[wp_q] = {fadd_y, fadd_ovf, st_q[NSTAGE-1]};
      wp_d        = nxt(wp_q);
    end
    if (pop) begin
      rp_d = nxt(rp_q);
    end
    cnt_d = cnt_q;
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
    cred_d = cred_q;
    unique case ({accept, pop})
      2'b10:   cred_d = cred_q + 1'b1;
      2'b01:   cred_d = cred_q - 1'b1;
      default: cred_d = cred_q;
    endcase
    perr_d = perr_q | (fadd_enable_out != sv_q[NSTAGE-1]);
  end

  // State registers; reset discards everything in flight or buffered.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      x1_q   <= '0;
      x2_q   <= '0;
      en_q   <= 1'b0;
      itag_q <= '0;
      sv_q   <= '0;
      for (int i = 0; i < NSTAGE; i++) st_q[i] <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wp_q   <= '0;
      rp_q   <= '0;
      cnt_q  <= '0;
      cred_q <= '0;
      perr_q <= 1'b0;
    end else begin
      x1_q   <= x1_d;
      x2_q   <= x2_d;
      en_q   <= en_d;
      itag_q <= itag_d;
      sv_q   <= sv_d;
      st_q   <= st_d;
      mem_q  <= mem_d;
      wp_q   <= wp_d;
      rp_q   <= rp_d;
      cnt_q  <= cnt_d;
      cred_q <= cred_d;
      perr_q <= perr_d;
    end
  end

`ifndef SYNTHESIS
  // Credits bound the FIFO, so they can never exceed its depth.
  always_ff @(posedge clk) begin
    if (rstn) assert (cred_q <= DEPTH_C);
  end
`endif

endmodule

// File: tb/tb_fadd_issue.sv
// tb_fadd_issue: bench for fadd_issue with a behavioural 2-stage fadd.
// Table vectors plus scoreboard over every accept and pop.
module tb_fadd_issue;

  localparam int NSTAGE = 2;
  localparam int DEPTH  = NSTAGE + 2;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_x1 = '0;
  logic [31:0] req_x2 = '0;
  logic [3:0]  req_tag = '0;
  logic [31:0] fadd_x1, fadd_x2;
  logic        fadd_enable_in;
  logic        fadd_enable_out;
  logic [31:0] fadd_y;
  logic        fadd_ovf;
  logic        res_valid;
  logic        res_ready = 1'b0;
  logic [31:0] res_y;
  logic        res_ovf;
  logic [3:0]  res_tag;
  logic [2:0]  credits_used;
  logic        proto_err;
  logic        force_eo = 1'b0;

  int checks = 0;
  int failures = 0;
  int acc_cnt = 0;
  int pop_cnt = 0;

  always #5 clk = ~clk;

  fadd_issue #(.NSTAGE(NSTAGE), .TAGW(4)) dut (
    .clk(clk), .rstn(rstn),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_x1(req_x1), .req_x2(req_x2), .req_tag(req_tag),
    .fadd_x1(fadd_x1), .fadd_x2(fadd_x2),
    .fadd_enable_in(fadd_enable_in),
    .fadd_enable_out(fadd_enable_out),
    .fadd_y(fadd_y), .fadd_ovf(fadd_ovf),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_y(res_y), .res_ovf(res_ovf), .res_tag(res_tag),
    .credits_used(credits_used), .proto_err(proto_err)
  );

  function automatic real s2r(input logic [31:0] a);
    logic [63:0] b;
    if (a[30:23] == 8'd0) return 0.0;
    b = {a[31], 11'(a[30:23]) + 11'd896, a[22:0], 29'd0};
    return $bitstoreal(b);
  endfunction

  // returns {ovf, y}; normals only, truncating
  function automatic logic [32:0] fsum(input logic [31:0] a,
                                       input logic [31:0] c);
    logic [63:0] b;
    int ee;
    b = $realtobits(s2r(a) + s2r(c));
    ee = int'(b[62:52]) - 896;
    if (b[62:0] == 63'd0) return {2'b00, 31'd0};
    if (ee >= 255) return {1'b1, b[63], 8'hFF, 23'd0};
    if (ee <= 0) return {1'b0, b[63], 31'd0};
    return {1'b0, b[63], ee[7:0], b[51:29]};
  endfunction

  logic [1:0]  fe;
  logic [32:0] fr0, fr1;

  // behavioural fadd, latency NSTAGE
  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      fe <= '0;
    end else begin
      fe  <= {fe[0], fadd_enable_in};
      fr0 <= fsum(fadd_x1, fadd_x2);
      fr1 <= fr0;
    end
  end
  assign fadd_enable_out = fe[1] | force_eo;
  assign fadd_y          = fr1[31:0];
  assign fadd_ovf        = fr1[32];

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  logic [36:0] sbq [$];

  // scoreboard: push expected on accept, compare on pop
  always @(negedge clk) begin
    if (!rstn) begin
      sbq.delete();
    end else begin
      if (req_valid && req_ready) begin
        sbq.push_back({fsum(req_x1, req_x2), req_tag});
        acc_cnt++;
      end
      if (res_valid && res_ready) begin
        pop_cnt++;
        if (sbq.size() == 0) begin
          chk("sb_unexpected_pop", 64'(res_tag), 64'hFFFF);
        end else begin
          logic [36:0] e;
          e = sbq.pop_front();
          chk("sb_result", 64'({res_ovf, res_y, res_tag}), 64'(e));
        end
      end
    end
  end

  typedef struct {
    logic [31:0] x1;
    logic [31:0] x2;
    logic [3:0]  tag;
    logic [31:0] y;
    logic        ovf;
  } vec_t;

  vec_t vt [6];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input int i);
    int lat;
    res_ready = 1'b0;
    req_x1 = vt[i].x1;
    req_x2 = vt[i].x2;
    req_tag = vt[i].tag;
    req_valid = 1'b1;
    chk("vec_ready", 64'(req_ready), 64'd1);
    tick();
    req_valid = 1'b0;
    chk("vec_en_in_hi", 64'(fadd_enable_in), 64'd1);
    chk("vec_fadd_x1", 64'(fadd_x1), 64'(vt[i].x1));
    chk("vec_credits1", 64'(credits_used), 64'd1);
    tick();
    lat = 1;
    chk("vec_en_in_lo", 64'(fadd_enable_in), 64'd0);
    while (!res_valid && lat < 20) begin
      tick();
      lat++;
    end
    chk("vec_latency", 64'(lat), 64'(NSTAGE + 1));
    chk("vec_y", 64'(res_y), 64'(vt[i].y));
    chk("vec_ovf", 64'(res_ovf), 64'(vt[i].ovf));
    chk("vec_tag", 64'(res_tag), 64'(vt[i].tag));
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    chk("vec_popped", 64'(res_valid), 64'd0);
    chk("vec_credits0", 64'(credits_used), 64'd0);
  endtask

  task automatic drain();
    int n;
    n = 0;
    res_ready = 1'b1;
    while (credits_used != 0 && n < 40) begin
      tick();
      n++;
    end
    chk("drain_credits", 64'(credits_used), 64'd0);
    res_ready = 1'b0;
  endtask

  initial begin
    int nacc, a0, p0, sent, cyc, maxc;
    logic acc, pp, same_done, rvseen;
    logic [2:0] cb;
    logic [31:0] hy;

    vt[0] = '{32'h3F800000, 32'h40000000, 4'd5, 32'h40400000, 1'b0};
    vt[1] = '{32'h7F7FFFFF, 32'h7F7FFFFF, 4'd9, 32'h7F800000, 1'b1};
    vt[2] = '{32'h3F800000, 32'hBF800000, 4'd2, 32'h00000000, 1'b0};
    vt[3] = '{32'h40400000, 32'h40800000, 4'd7, 32'h40E00000, 1'b0};
    vt[4] = '{32'h3FC00000, 32'h3FC00000, 4'd15, 32'h40400000, 1'b0};
    vt[5] = '{32'hC0000000, 32'hBF800000, 4'd0, 32'hC0400000, 1'b0};

    repeat (3) tick();
    chk("rst_res_valid", 64'(res_valid), 64'd0);
    chk("rst_en_in", 64'(fadd_enable_in), 64'd0);
    chk("rst_fadd_x1", 64'({fadd_x1, fadd_x2}), 64'd0);
    chk("rst_credits", 64'(credits_used), 64'd0);
    chk("rst_proto", 64'(proto_err), 64'd0);
    chk("rst_res", 64'({res_y, res_ovf, res_tag}), 64'd0);
    rstn = 1'b1;
    tick();
    chk("rst_ready", 64'(req_ready), 64'd1);

    for (int i = 0; i < 6; i++) run_vec(i);

    // backpressure: exactly DEPTH accepts
    nacc = 0;
    a0 = acc_cnt;
    res_ready = 1'b0;
    req_valid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      req_tag = 4'(nacc);
      req_x1 = 32'h3F800000 + 32'(nacc << 20);
      req_x2 = 32'h40000000;
      acc = req_ready;
      tick();
      if (acc) begin
        nacc++;
        if (nacc == DEPTH)
          chk("bp_ready_fall", 64'(req_ready), 64'd0);
      end
    end
    chk("bp_accepts", 64'(nacc), 64'(DEPTH));
    chk("bp_ready_low", 64'(req_ready), 64'd0);
    chk("bp_res_valid", 64'(res_valid), 64'd1);
    req_tag = 4'd4;
    res_ready = 1'b1;
    tick();
    chk("bp_ready_rise", 64'(req_ready), 64'd1);
    chk("bp_cred_after_pop", 64'(credits_used), 64'd3);
    tick();
    req_valid = 1'b0;
    chk("bp_cred_same_edge", 64'(credits_used), 64'd3);
    drain();
    chk("bp_total_accepts", 64'(acc_cnt - a0), 64'(DEPTH + 1));

    // streaming 100 ops with res_ready held
    p0 = pop_cnt;
    sent = 0;
    cyc = 0;
    maxc = 0;
    same_done = 1'b0;
    res_ready = 1'b1;
    while ((sent < 100 || pop_cnt - p0 < 100) && cyc < 2000) begin
      req_valid = (sent < 100);
      req_x1 = {1'($urandom), 8'($urandom_range(64, 190)), 23'($urandom)};
      req_x2 = {1'($urandom), 8'($urandom_range(64, 190)), 23'($urandom)};
      req_tag = 4'(sent);
      acc = req_valid && req_ready;
      pp = res_valid && res_ready;
      cb = credits_used;
      tick();
      cyc++;
      if (acc) sent++;
      if (acc && pp && !same_done) begin
        chk("stream_same_edge", 64'(credits_used), 64'(cb));
        same_done = 1'b1;
      end
      if (int'(credits_used) > maxc) maxc = int'(credits_used);
    end
    req_valid = 1'b0;
    chk("stream_sent", 64'(sent), 64'd100);
    chk("stream_pops", 64'(pop_cnt - p0), 64'd100);
    chk("stream_max_credits_ok", 64'(maxc <= DEPTH), 64'd1);
    chk("stream_same_seen", 64'(same_done), 64'd1);
    chk("stream_proto", 64'(proto_err), 64'd0);
    drain();

    // reset while three ops are in flight
    res_ready = 1'b0;
    rvseen = 1'b0;
    req_valid = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      req_tag = 4'(k);
      req_x1 = vt[3].x1;
      req_x2 = vt[3].x2;
      tick();
      rvseen |= res_valid;
    end
    req_valid = 1'b0;
    rstn = 1'b0;
    tick();
    rvseen |= res_valid;
    tick();
    rvseen |= res_valid;
    rstn = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      rvseen |= res_valid;
    end
    chk("mrst_no_result", 64'(rvseen), 64'd0);
    chk("mrst_credits", 64'(credits_used), 64'd0);
    chk("mrst_ready", 64'(req_ready), 64'd1);
    run_vec(0);

    // spurious enable_out flags proto_err, FIFO untouched
    req_x1 = vt[4].x1;
    req_x2 = vt[4].x2;
    req_tag = vt[4].tag;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    cyc = 0;
    while (!res_valid && cyc < 20) begin
      tick();
      cyc++;
    end
    chk("pe_res_valid", 64'(res_valid), 64'd1);
    chk("pe_before", 64'(proto_err), 64'd0);
    hy = res_y;
    force_eo = 1'b1;
    tick();
    force_eo = 1'b0;
    chk("pe_set", 64'(proto_err), 64'd1);
    chk("pe_fifo_y", 64'(res_y), 64'(vt[4].y));
    chk("pe_fifo_same", 64'(res_y), 64'(hy));
    chk("pe_credits", 64'(credits_used), 64'd1);
    repeat (3) tick();
    chk("pe_sticky", 64'(proto_err), 64'd1);
    chk("pe_still_one", 64'(res_valid), 64'd1);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    chk("pe_popped", 64'(res_valid), 64'd0);
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    tick();
    chk("pe_cleared", 64'(proto_err), 64'd0);
    chk("sb_empty_end", 64'(sbq.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
